// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dm_access_ctrl_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned DM_AW_DEFAULT = 14;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_e;

    function automatic logic [2:0] size_bytes(size_e s);
        case (s)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(logic [DATA_WIDTH-1:0] d, size_e s, logic uns);
        case (s)
            SZ_B:    return uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            SZ_H:    return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            SZ_W:    return d;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response handshake plus SRAM port bundle for dm_access_ctrl.
interface dm_access_ctrl_if #(
    parameter int unsigned DM_AW = dm_access_ctrl_pkg::DM_AW_DEFAULT
) ();

    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [1:0]       req_size_i;
    logic             req_unsigned_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic             rsp_valid_o;
    logic [31:0]      rsp_rdata_o;
    logic             rsp_split_o;
    logic             DM_CS_o;
    logic             DM_OE_o;
    logic [3:0]       DM_WEB_o;
    logic [DM_AW-1:0] DM_A_o;
    logic [31:0]      DM_DI_o;
    logic [31:0]      DM_DO_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, DM_DO_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_split_o,
        output DM_CS_o, DM_OE_o, DM_WEB_o, DM_A_o, DM_DI_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, DM_DO_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_split_o,
        input  DM_CS_o, DM_OE_o, DM_WEB_o, DM_A_o, DM_DI_o
    );

endinterface

// File: rtl/dm_access_ctrl_lane_shift.sv
// Byte-lane geometry for one SRAM access cycle: lane mask, lane-aligned
// write data, and read bytes moved back to their request positions.
module dm_lane_shift
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        phase,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  lane_mask,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_pos,
    output logic        split
);

    logic [2:0]  span_end;
    logic [5:0]  sh_lo;
    logic [5:0]  sh_hi;
    logic [31:0] byte_mask;

    always_comb begin
        span_end  = {1'b0, offset} + size_bytes(size);
        split     = (span_end > 3'd4) && (size != SZ_BAD);
        sh_lo     = {1'b0, offset, 3'b000};
        sh_hi     = 6'd32 - sh_lo;
        lane_mask = '0;
        byte_mask = '0;
        // phase 1 covers the bytes that spilled past lane 3 into the next word
        for (int unsigned i = 0; i < 4; i++) begin
            if (phase)
                lane_mask[i] = ({1'b0, 2'(i)} + 3'd4) < span_end;
            else
                lane_mask[i] = ({1'b0, 2'(i)} >= {1'b0, offset}) && ({1'b0, 2'(i)} < span_end);
            byte_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        if (phase) begin
            wdata_lanes = (wdata >> sh_hi) & byte_mask;
            rdata_pos   = (rdata & byte_mask) << sh_hi;
        end else begin
            wdata_lanes = (wdata << sh_lo) & byte_mask;
            rdata_pos   = (rdata & byte_mask) >> sh_lo;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller for a word-wide data SRAM; unaligned accesses that
// cross a word boundary take a second SRAM cycle.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned DM_AW = DM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    dm_access_ctrl_if.slave   bus
);

    state_e           state;
    logic             r_we;
    size_e            r_size;
    logic             r_uns;
    logic [1:0]       r_off;
    logic [DM_AW-1:0] r_wa;
    logic [31:0]      r_wdata;
    logic [31:0]      asm_q;
    logic             rsp_valid;
    logic             rsp_split;
    logic [31:0]      rsp_rdata;

    logic             access;
    logic [3:0]       lane_mask;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rdata_pos;
    logic [31:0]      asm_next;
    logic             split;
    logic             dm_oe;
    logic [3:0]       dm_web;
    logic [DM_AW-1:0] dm_a;
    logic [31:0]      dm_di;

    dm_lane_shift u_lane (
        .offset      (r_off),
        .size        (r_size),
        .phase       (state == ACC1),
        .wdata       (r_wdata),
        .rdata       (bus.DM_DO_i),
        .lane_mask   (lane_mask),
        .wdata_lanes (wdata_lanes),
        .rdata_pos   (rdata_pos),
        .split       (split)
    );

    assign access   = (state == ACC0) || (state == ACC1);
    assign asm_next = asm_q | rdata_pos;

    always_comb begin
        dm_oe  = access && !r_we;
        dm_web = '1;
        dm_a   = '0;
        dm_di  = '0;
        if (access) begin
            dm_a = (state == ACC1) ? r_wa + {{(DM_AW-1){1'b0}}, 1'b1} : r_wa;
            if (r_we && r_size != SZ_BAD) begin
                dm_web = ~lane_mask;
                dm_di  = wdata_lanes;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_size    <= SZ_B;
            r_uns     <= 1'b0;
            r_off     <= '0;
            r_wa      <= '0;
            r_wdata   <= '0;
            asm_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_split <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_we    <= bus.req_we_i;
                        r_size  <= size_e'(bus.req_size_i);
                        r_uns   <= bus.req_unsigned_i;
                        r_off   <= bus.req_addr_i[1:0];
                        r_wa    <= bus.req_addr_i[DM_AW+1:2];
                        r_wdata <= bus.req_wdata_i;
                        asm_q   <= '0;
                        state   <= ACC0;
                    end
                end
                ACC0: begin
                    asm_q <= asm_next;
                    if (split) begin
                        state <= ACC1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_split <= 1'b0;
                        rsp_rdata <= r_we ? '0 : load_extend(asm_next, r_size, r_uns);
                    end
                end
                ACC1: begin
                    asm_q     <= asm_next;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_split <= 1'b1;
                    rsp_rdata <= r_we ? '0 : load_extend(asm_next, r_size, r_uns);
                end
                default: begin
                    state     <= IDLE;
                    rsp_split <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state == IDLE);
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_split_o = rsp_split;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.DM_CS_o     = access;
    assign bus.DM_OE_o     = dm_oe;
    assign bus.DM_WEB_o    = dm_web;
    assign bus.DM_A_o      = dm_a;
    assign bus.DM_DI_o     = dm_di;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed vector table, back-to-back and reset
// sequences, then random traffic checked against a byte-array memory model.
module tb_dm_access_ctrl;

    localparam int unsigned DM_AW = 14;
    localparam int          AMASK = (1 << (DM_AW + 2)) - 1;

    logic clk;
    logic rst_n;

    dm_access_ctrl_if #(.DM_AW(DM_AW)) bus ();

    dm_access_ctrl #(.DM_AW(DM_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model seen by the DUT; garbage on DO when not selected
    bit [31:0] sram [0:(1<<DM_AW)-1];
    bit [7:0]  ref_mem [0:AMASK];

    assign bus.DM_DO_i = bus.DM_CS_o ? sram[bus.DM_A_o] : 32'h5A5A_5A5A;

    always @(posedge clk) begin
        if (bus.DM_CS_o)
            for (int i = 0; i < 4; i++)
                if (!bus.DM_WEB_o[i]) sram[bus.DM_A_o][8*i +: 8] <= bus.DM_DI_o[8*i +: 8];
    end

    int n_err;
    int n_checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [15:0] a, input int nb, input logic uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++)
            v = v | (32'(ref_mem[(int'(a) + i) & AMASK]) << (8 * i));
        if (nb < 4 && !uns && v[8*nb-1])
            v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic ref_store(input logic [15:0] a, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++)
            ref_mem[(int'(a) + i) & AMASK] = wd[8*i +: 8];
    endtask

    // results of the most recent transaction
    int               got_nacc;
    int               got_lat;
    bit               got_rsp;
    logic [DM_AW-1:0] acc_a   [2];
    logic [3:0]       acc_web [2];
    logic [31:0]      acc_di  [2];
    logic             acc_oe  [2];
    logic [31:0]      got_rdata;
    logic             got_split;

    task automatic run_txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        int w;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        w = 0;
        while (!bus.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        got_nacc = 0;
        got_lat  = 0;
        got_rsp  = 1'b0;
        for (int j = 0; j < 2; j++) begin
            acc_a[j] = '0; acc_web[j] = '1; acc_di[j] = '0; acc_oe[j] = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            if (bus.DM_CS_o) begin
                if (got_nacc < 2) begin
                    acc_a[got_nacc]   = bus.DM_A_o;
                    acc_web[got_nacc] = bus.DM_WEB_o;
                    acc_di[got_nacc]  = bus.DM_DI_o;
                    acc_oe[got_nacc]  = bus.DM_OE_o;
                end
                got_nacc++;
            end
            if (bus.rsp_valid_o) begin
                got_rsp   = 1'b1;
                got_lat   = k;
                got_rdata = bus.rsp_rdata_o;
                got_split = bus.rsp_split_o;
                break;
            end
            @(negedge clk);
        end
        if (!got_rsp) begin
            n_checks++;
            n_err++;
            $display("FAIL %s.timeout: got no rsp_valid expected rsp_valid within 8 cycles", tag);
        end
    endtask

    typedef struct {
        logic             we;
        logic [1:0]       size;
        logic             uns;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        int               nacc;
        logic [DM_AW-1:0] a0;
        logic [3:0]       web0;
        logic [31:0]      di0;
        logic [DM_AW-1:0] a1;
        logic [3:0]       web1;
        logic [31:0]      di1;
        logic [31:0]      rdata;
        logic             split;
        int               lat;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string nm;
        int    pulses;

        n_err    = 0;
        n_checks = 0;
        // we size uns addr wdata | nacc a0 web0 di0 a1 web1 di1 | rdata split lat
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 1, 14'h040, 4'b0000, 32'hDEADBEEF, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 1, 14'h040, 4'b0111, 32'hA500_0000, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'hABCD_0103, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'hFFFF_FFA5, 1'b0, 2};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'h0000_00A5, 1'b0, 2};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0107, 32'h0000_1234, 2, 14'h041, 4'b0111, 32'h3400_0000, 14'h042, 4'b1110, 32'h0000_0012, 32'h0, 1'b1, 3};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0107, 32'h0, 2, 14'h041, 4'b1111, 32'h0, 14'h042, 4'b1111, 32'h0, 32'h0000_1234, 1'b1, 3};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'hA5AD_BEEF, 1'b0, 2};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_8001, 1, 14'h040, 4'b0011, 32'h8001_0000, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'hFFFF_8001, 1'b0, 2};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'h0000_00BE, 1'b0, 2};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_FFFE, 32'h1122_3344, 2, 14'h3FFF, 4'b0011, 32'h3344_0000, 14'h000, 4'b1100, 32'h0000_1122, 32'h0, 1'b1, 3};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_FFFE, 32'h0, 2, 14'h3FFF, 4'b1111, 32'h0, 14'h000, 4'b1111, 32'h0, 32'h1122_3344, 1'b1, 3};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 1, 14'h080, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 1, 14'h080, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};
        vecs[14] = '{1'b0, 2'd3, 1'b0, 32'h0000_0102, 32'h0, 1, 14'h040, 4'b1111, 32'h0, 14'h0, 4'hF, 32'h0, 32'h0, 1'b0, 2};

        rst_n              = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;

        repeat (2) @(negedge clk);
        chk("rst.cs",        32'(bus.DM_CS_o),     32'd0);
        chk("rst.web",       32'(bus.DM_WEB_o),    32'hF);
        chk("rst.a",         32'(bus.DM_A_o),      32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(bus.req_ready_o), 32'd1);

        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            run_txn(nm, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            chk({nm, ".nacc"}, 32'(got_nacc), 32'(vecs[i].nacc));
            chk({nm, ".a0"},   32'(acc_a[0]),   32'(vecs[i].a0));
            chk({nm, ".web0"}, 32'(acc_web[0]), 32'(vecs[i].web0));
            chk({nm, ".oe0"},  32'(acc_oe[0]),  32'(!vecs[i].we));
            if (vecs[i].we && vecs[i].size != 2'd3)
                chk({nm, ".di0"}, acc_di[0], vecs[i].di0);
            if (vecs[i].nacc == 2) begin
                chk({nm, ".a1"},   32'(acc_a[1]),   32'(vecs[i].a1));
                chk({nm, ".web1"}, 32'(acc_web[1]), 32'(vecs[i].web1));
                if (vecs[i].we)
                    chk({nm, ".di1"}, acc_di[1], vecs[i].di1);
            end
            chk({nm, ".rdata"}, got_rdata,        vecs[i].rdata);
            chk({nm, ".split"}, 32'(got_split),   32'(vecs[i].split));
            chk({nm, ".lat"},   32'(got_lat),     32'(vecs[i].lat));
            if (vecs[i].we && vecs[i].size != 2'd3)
                ref_store(vecs[i].addr[15:0], (vecs[i].size == 2'd0) ? 1 : (vecs[i].size == 2'd1) ? 2 : 4, vecs[i].wdata);
        end

        // back-to-back: requests taken only every third cycle
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_size_i  = 2'd2;
        bus.req_addr_i  = 32'h0000_0100;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("b2b.ready%0d", c), 32'(bus.req_ready_o), 32'((c % 3) == 0));
            chk($sformatf("b2b.rsp%0d", c),   32'(bus.rsp_valid_o), 32'((c % 3) == 2));
            if (bus.rsp_valid_o)
                chk($sformatf("b2b.rdata%0d", c), bus.rsp_rdata_o, model_load(16'h0100, 4, 1'b0));
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic        we, uns, esp;
            logic [1:0]  sz;
            logic [31:0] ad, wd, erd;
            int          nb;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad  = {16'($urandom), (($urandom_range(0, 1) != 0) ? 16'hFFC0 : 16'h0000) + 16'($urandom_range(0, 63))};
            wd  = $urandom;
            nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            esp = (sz != 2'd3) && ((int'(ad[1:0]) + nb) > 4);
            erd = (sz == 2'd3 || we) ? 32'h0 : model_load(ad[15:0], nb, uns);
            nm  = $sformatf("r%0d", i);
            run_txn(nm, we, sz, uns, ad, wd);
            chk({nm, ".rdata"}, got_rdata,      erd);
            chk({nm, ".split"}, 32'(got_split), 32'(esp));
            chk({nm, ".lat"},   32'(got_lat),   esp ? 32'd3 : 32'd2);
            chk({nm, ".nacc"},  32'(got_nacc),  esp ? 32'd2 : 32'd1);
            if (we && sz != 2'd3) ref_store(ad[15:0], nb, wd);
        end

        // reset in the second cycle of a split half store at 0x107
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_size_i  = 2'd1;
        bus.req_addr_i  = 32'h0000_0107;
        bus.req_wdata_i = 32'h0000_BEEF;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst2.in_acc1", 32'(bus.DM_A_o), 32'h042);
        #1 rst_n = 1'b0;
        #1;
        chk("rst2.cs",    32'(bus.DM_CS_o),     32'd0);
        chk("rst2.oe",    32'(bus.DM_OE_o),     32'd0);
        chk("rst2.web",   32'(bus.DM_WEB_o),    32'hF);
        chk("rst2.a",     32'(bus.DM_A_o),      32'd0);
        chk("rst2.di",    bus.DM_DI_o,          32'd0);
        chk("rst2.ready", 32'(bus.req_ready_o), 32'd1);
        pulses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.rsp_valid_o) pulses++;
            @(negedge clk);
        end
        chk("rst2.no_rsp", 32'(pulses), 32'd0);
        ref_mem[16'h0107] = 8'hEF;
        run_txn("rst2.load", 1'b0, 2'd1, 1'b1, 32'h0000_0107, 32'h0);
        chk("rst2.rdata", got_rdata,      model_load(16'h0107, 2, 1'b1));
        chk("rst2.split", 32'(got_split), 32'd1);
        chk("rst2.lat",   32'(got_lat),   32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
